// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter.
// Enables the ring around a delay chain, synchronises its output into clk and
// counts rising edges over a programmable window. A start/done handshake
// returns the count plus a sticky saturation flag.
// Optional feature macro: RO_PRESCALE_EN adds a PRE_LOG2-bit divider clocked by
// ro_in in front of the synchroniser, so faster rings can be measured.
module ro_freq_counter #(
  parameter int CNT_W         = 16,
  parameter int WIN_W         = 16,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2
`ifdef RO_PRESCALE_EN
  ,
  parameter int PRE_LOG2      = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] gate_cycles,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_GATE   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Timer terminal values: SETTLE lasts SETTLE_CYCLES, DRAIN lasts SYNC_STAGES+1.
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST  = 8'(SYNC_STAGES);

  state_t                 r_state;
  logic [7:0]             r_tmr;
  logic [WIN_W-1:0]       r_win;
  logic [CNT_W-1:0]       r_edge;
  logic                   r_ovf_acc;
  logic                   r_ro_en;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ovf;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_sync_in;
  logic                   w_edge;

`ifdef RO_PRESCALE_EN
  logic [PRE_LOG2-1:0] r_pre;
  logic                w_pre_clr_n;

  // Divider is held cleared whenever the ring is disabled so every window
  // starts from the same prescaler phase.
  assign w_pre_clr_n = rst_n & r_ro_en;

  // Prescaler counting ring edges in the ro_in domain.
  always_ff @(posedge ro_in or negedge w_pre_clr_n) begin
    if (!w_pre_clr_n) r_pre <= '0;
    else              r_pre <= r_pre + 1'b1;
  end

  assign w_sync_in = r_pre[PRE_LOG2-1];
`else
  assign w_sync_in = ro_in;
`endif

  // Multi-flop synchroniser followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_sync_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_hist;

  // Measurement FSM with registered handshake outputs and saturating counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_win     <= '0;
      r_edge    <= '0;
      r_ovf_acc <= 1'b0;
      r_ro_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_state <= S_IDLE;
          if (start) begin
            if (gate_cycles == '0) begin
              // Empty window: report a zero result without touching the ring.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_count <= '0;
              r_ovf   <= 1'b0;
            end else begin
              r_win     <= gate_cycles;
              r_edge    <= '0;
              r_ovf_acc <= 1'b0;
              r_ro_en   <= 1'b1;
              r_busy    <= 1'b1;
              r_tmr     <= '0;
              r_state   <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_ro_en <= 1'b0;
            r_busy  <= 1'b0;
            r_tmr   <= '0;
          end else if (r_tmr == SETTLE_LAST) begin
            r_tmr   <= '0;
            r_state <= S_GATE;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        S_GATE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_ro_en <= 1'b0;
            r_busy  <= 1'b0;
            r_tmr   <= '0;
          end else begin
            if (w_edge) begin
              if (&r_edge) r_ovf_acc <= 1'b1;
              else         r_edge    <= r_edge + 1'b1;
            end
            if (r_win == WIN_W'(1)) begin
              r_state <= S_DRAIN;
              r_ro_en <= 1'b0;
            end
            r_win <= r_win - WIN_W'(1);
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_tmr   <= '0;
          end else if (r_tmr == DRAIN_LAST) begin
            r_tmr   <= '0;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_count <= r_edge;
            r_ovf   <= r_ovf_acc;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ro_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ro_en    = r_ro_en;
  assign busy     = r_busy;
  assign done     = r_done;
  assign count    = r_count;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Testbench for ro_freq_counter: two instances (16-bit and 4-bit counters)
// share all inputs; expected counts come from the recorded ro_in waveform.
module tb_ro_freq_counter;

  localparam int SET = 8;
  localparam int SYN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] gate_cycles = 16'd0;
  logic        ro_in = 1'b0;

  logic        ro_en, busy, done, overflow;
  logic [15:0] count;
  logic        ro_en4, busy4, done4, overflow4;
  logic [3:0]  count4;

  int n_chk = 0;
  int n_fail = 0;

  int gen_mode = 0;
  int gen_per = 8;
  int gen_ph = 0;
  int pc = 0;

  bit samp [0:65535];
  int cyc = 0;

  ro_freq_counter #(.CNT_W(16), .WIN_W(16), .SETTLE_CYCLES(SET), .SYNC_STAGES(SYN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_cycles(gate_cycles),
    .ro_in(ro_in), .ro_en(ro_en), .busy(busy), .done(done), .count(count), .overflow(overflow));

  ro_freq_counter #(.CNT_W(4), .WIN_W(16), .SETTLE_CYCLES(SET), .SYNC_STAGES(SYN)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .gate_cycles(gate_cycles),
    .ro_in(ro_in), .ro_en(ro_en4), .busy(busy4), .done(done4), .count(count4), .overflow(overflow4));

  always #5 clk = ~clk;

  // Ring model: square wave (mode 0) or random bits (1) while enabled, or free noise (2).
  always @(negedge clk) begin
    if (gen_mode == 2) begin
      ro_in <= 1'($urandom_range(0, 1));
    end else if (!ro_en) begin
      ro_in <= 1'b0;
      pc    <= 0;
    end else begin
      if (gen_mode == 1) ro_in <= 1'($urandom_range(0, 1));
      else               ro_in <= (((pc + gen_ph) % gen_per) < (gen_per / 2));
      pc <= pc + 1;
    end
  end

  // Record the value of ro_in seen at every rising clk edge.
  always @(posedge clk) begin
    samp[cyc[15:0]] <= ro_in;
    cyc <= cyc + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Rising edges of ro_in between sample indices lo..hi inclusive.
  function automatic int rises(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++)
      if (samp[j[15:0]] && !samp[16'(j - 1)]) n++;
    return n;
  endfunction

  // One complete measurement; pulse_at>1 injects an ignored start while busy.
  task automatic measure(input int g, input int pulse_at, input bit chain, output int n_edges);
    int e0, lat, bad_busy, bad_en, exp_lat, n;
    lat = -1; bad_busy = 0; bad_en = 0;
    gate_cycles = g[15:0];
    start = 1'b1;
    e0 = cyc;
    for (int m = 1; m <= 2000; m++) begin
      step();
      if (m == 1) begin
        start = 1'b0;
        gate_cycles = 16'($urandom);
      end
      if (m == pulse_at) start = 1'b1;
      else if (pulse_at > 1 && m == pulse_at + 1) start = 1'b0;
      if (done) begin
        lat = m;
        break;
      end
      if (g != 0) begin
        if (busy !== 1'b1) bad_busy++;
        if (ro_en !== (m <= SET + g)) bad_en++;
      end else if (ro_en !== 1'b0) bad_en++;
    end
    exp_lat = (g == 0) ? 1 : 1 + SET + g + SYN + 1;
    n = (g == 0) ? 0 : rises(e0 + SET - SYN + 1, e0 + SET + g - SYN);
    n_edges = n;
    chk("latency", lat, exp_lat);
    chk("busy_profile", bad_busy, 0);
    chk("ro_en_profile", bad_en, 0);
    chk("busy_at_done", busy, 0);
    chk("ro_en_at_done", ro_en, 0);
    chk("done4", done4, 1);
    chk("count16", count, n);
    chk("overflow16", overflow, 0);
    chk("count4", count4, (n > 15) ? 15 : n);
    chk("overflow4", overflow4, (n > 15) ? 1 : 0);
    if (!chain) begin
      step();
      chk("done_single_pulse", done, 0);
      chk("count_held", count, n);
    end
  endtask

  initial begin
    int n, bad, cnt_before;

    // Reset state
    gen_mode = 0; gen_per = 8; gen_ph = 0;
    repeat (3) step();
    chk("rst_ro_en", ro_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_count4", count4, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Basic count: period 8, window 64
    measure(64, -1, 1'b0, n);
    chk("basic_count_is_8", count, 8);

    // Saturation of the 4-bit instance, then a short clean run
    gen_per = 2;
    measure(100, -1, 1'b0, n);
    chk("sat_count4_15", count4, 15);
    chk("sat_overflow4", overflow4, 1);
    chk("sat_count16_50", count, 50);
    measure(4, -1, 1'b0, n);
    chk("short_count4_2", count4, 2);
    chk("short_overflow4", overflow4, 0);

    // Zero window
    measure(0, -1, 1'b0, n);
    chk("zero_count", count, 0);

    // Basic again, then abort in the 10th GATE cycle (start in same cycle too)
    gen_per = 8;
    measure(64, -1, 1'b0, n);
    gate_cycles = 16'd64;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int m = 2; m <= SET + 10; m++) step();
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abort_ro_en", ro_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    bad = 0;
    for (int m = 0; m < 100; m++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("abort_no_done", bad, 0);
    chk("abort_count_kept", count, 8);
    chk("abort_overflow_kept", overflow, 0);

    // Ignored start during GATE
    measure(64, SET + 20, 1'b0, n);
    chk("ignored_start_count", count, 8);

    // Abort while idle is ignored
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_count", count, 8);

    // Asynchronous reset in the middle of GATE
    gate_cycles = 16'd64;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int m = 2; m <= SET + 5; m++) step();
    cnt_before = count;
    chk("pre_reset_count", cnt_before, 8);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ro_en", ro_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_count", count, 0);
    chk("async_rst_overflow", overflow, 0);
    repeat (2) step();
    rst_n = 1'b1;
    bad = 0;
    for (int m = 0; m < 20; m++) begin
      step();
      if (ro_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || count !== 16'd0 || overflow !== 1'b0) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    // Back-to-back: re-arm from DONE
    measure(20, -1, 1'b1, n);
    measure(0, -1, 1'b1, n);
    measure(30, -1, 1'b0, n);

    // Randomised runs
    for (int r = 0; r < 24; r++) begin
      int g, pa;
      gen_mode = $urandom_range(0, 2);
      gen_per  = $urandom_range(2, 20);
      gen_ph   = $urandom_range(0, 19);
      g = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 300);
      pa = (g > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(2, SET + g) : -1;
      measure(g, pa, 1'($urandom_range(0, 1)), n);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
